cnn_frame_scheduler: RTL
========================

Name: cnn_frame_scheduler

Overview:
- Sequences one CNN frame at a time: on a MicroBlaze start command it pulses cnn_start/frame_start, then streams FRAME_PIXELS pixels from an internal FIFO into the CNN pixel interface.
- It then pulses frame_complete and waits for cnn_result_valid, with a watchdog timeout.
- Sits between the AXI-facing control register block and the CNN core, replacing per-pixel software pulsing with hardware streaming.

Parameters:
- PIX_W, 8, pixel data width.
- FRAME_PIXELS, 1024, pixels per frame (>=2).
- FIFO_DEPTH, 16, input pixel FIFO depth (power of 2, >=2).
- TIMEOUT_CYCLES, 100000, maximum cycles in WAIT_RESULT before a timeout error.

Ports:
- clk  in  1  single clock; all logic posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  level-sampled start request (one-cycle pulse from the control block).
- cmd_abort  in  1  abort the current frame.
- in_pixel_valid  in  1  pixel write valid.
- in_pixel_data  in  PIX_W  pixel write data.
- in_pixel_ready  out  1  FIFO not full; a write transfers when valid&&ready.
- cnn_busy  in  1  CNN core busy.
- cnn_result_valid  in  1  CNN result valid.
- cnn_start  out  1  one-cycle start pulse to the CNN.
- cnn_reset  out  1  one-cycle reset pulse to the CNN.
- frame_start  out  1  one-cycle frame-start pulse.
- pixel_valid  out  1  pixel strobe to the CNN.
- pixel_data  out  PIX_W  pixel to the CNN; holds its last value when pixel_valid=0.
- frame_complete  out  1  one-cycle pulse after the last pixel.
- sched_busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on a successful result.
- frame_count  out  32  count of successful frames; wraps 0xFFFFFFFF->0.
- error_code  out  32  0=NONE, 1=CNN_TIMEOUT, 2=INVALID_START, 3=ABORTED.

Behaviour:
- Reset (rst=1 at posedge):
  - All outputs 0; state=IDLE.
  - FIFO flushed, pixel index=0, timer=0, frame_count=0, error_code=0.
  - Reset mid-frame takes effect on the next edge; no pulses are emitted during reset.
- All outputs are registered.
- FIFO:
  - Accepts writes in any state when not full, including prefill in IDLE.
  - Flushed on abort and on timeout.
  - A push and a pop in the same cycle are allowed when the FIFO is full or empty-but-pushing; the occupancy count is unchanged.
- States: IDLE, START, STREAM, COMPLETE, WAIT_RESULT.
- IDLE:
  - cmd_start && !cnn_busy -> START, and error_code<=0.
  - cmd_start && cnn_busy -> stay in IDLE, error_code<=2.
  - cmd_abort in IDLE is ignored. If cmd_abort and cmd_start arrive together, the start is suppressed and error_code is unchanged.
- START: cnn_start=1 and frame_start=1 in the cycle after entry (one cycle each); pixel index<=0; -> STREAM.
- STREAM:
  - Each cycle the FIFO is non-empty: pop the head. The next cycle has pixel_valid=1 with pixel_data=head (one-cycle latency).
  - Index increments per pop. The pop with index==FRAME_PIXELS-1 -> COMPLETE.
  - An empty FIFO stalls streaming with no timeout; pixel_valid stays 0 during the stall.
- COMPLETE:
  - frame_complete=1 for one cycle, on the cycle after the last pixel_valid.
  - Timer<=0; -> WAIT_RESULT.
  - A cnn_result_valid in COMPLETE is ignored.
- WAIT_RESULT:
  - cnn_result_valid=1: frame_count+=1, frame_done pulse, -> IDLE.
  - Otherwise the timer increments. At timer==TIMEOUT_CYCLES-1: error_code<=1, cnn_reset pulse, FIFO flush, -> IDLE.
  - If a result and the timeout occur in the same cycle, the result wins.
- cmd_abort in any non-IDLE state:
  - Next state IDLE; cnn_reset pulse; FIFO flush; error_code<=3; frame_count unchanged.
  - Any pixel_valid/frame_complete not yet issued is suppressed.
  - Abort has priority over every other transition.
- cmd_start while sched_busy=1 is ignored; no error is raised.
- Pixels beyond FRAME_PIXELS remain in the FIFO for the next frame.

Decomposition:
- Package cnn_sched_pkg:
  - sched_state_t enum (3-bit).
  - Error constants ERR_NONE/ERR_CNN_TIMEOUT/ERR_INVALID_START/ERR_ABORTED, shared with the control register block.
- Sub-module cnn_pixel_fifo:
  - Synchronous FIFO with parameters DEPTH and WIDTH.
  - Signals push/pop/flush, full/empty/count.
  - Read data is registered on pop.

Test Plan (FRAME_PIXELS=4, FIFO_DEPTH=4, TIMEOUT_CYCLES=8):
- Happy path: prefill 0x11,0x22,0x33,0x44, then pulse cmd_start -> cnn_start/frame_start once, pixel_valid on 4 consecutive cycles with data 11,22,33,44, frame_complete once; cnn_result_valid 3 cycles later -> frame_done, frame_count=1, error_code=0.
- Stall: cmd_start with an empty FIFO, then write one pixel every 5 cycles -> exactly 4 pixel_valid pulses, each 2 cycles after its write. in_pixel_ready stays 1; no timeout.
- Timeout: complete streaming with no result -> after 8 WAIT_RESULT cycles error_code=1, cnn_reset pulse, sched_busy=0, frame_count unchanged.
- Invalid start: cnn_busy=1 with cmd_start -> stays IDLE, error_code=2. A later valid start clears error_code to 0.
- Abort mid-stream after 2 pixels -> cnn_reset pulse, error_code=3, no frame_complete, FIFO empty.
- Simultaneous result and timeout, plus frame_count preset to 0xFFFFFFFF -> frame_done fires, error_code=0, frame_count=0. Full FIFO: push with in_pixel_ready=0 is dropped and the count stays at 4.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// Shared types and constants for the CNN frame scheduler and the control
// register block that decodes its error code.
package cnn_sched_pkg;

    // Scheduler FSM encoding; the values are visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START       = 3'd1,
        ST_STREAM      = 3'd2,
        ST_COMPLETE    = 3'd3,
        ST_WAIT_RESULT = 3'd4
    } sched_state_t;

    // Error codes reported on error_code.
    localparam logic [31:0] ERR_NONE          = 32'd0;
    localparam logic [31:0] ERR_CNN_TIMEOUT   = 32'd1;
    localparam logic [31:0] ERR_INVALID_START = 32'd2;
    localparam logic [31:0] ERR_ABORTED       = 32'd3;

endpackage

// File: rtl/cnn_pixel_fifo.sv
// Synchronous pixel FIFO. Read data is registered on pop and holds between
// pops. A pop on an empty FIFO that is being pushed in the same cycle passes
// the write data straight through; a push on a full FIFO being popped in the
// same cycle is accepted. Flush empties the FIFO and drops any push that cycle.
// Full is held high during reset so writers back off until the FIFO is live.
module cnn_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_rdata;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (!r_full || i_pop);
    assign w_do_pop  = i_pop && (!r_empty || i_push);

    assign o_rdata = r_rdata;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

    // Occupancy after this cycle's push/pop/flush.
    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage array; no reset needed since occupancy guards every read.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers, flags and the registered read port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b1;
            r_empty  <= 1'b1;
            r_rdata  <= '0;
        end else begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_CNT);
            r_empty <= (w_count_next == '0);
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_rdata  <= r_empty ? i_wdata : r_mem[r_rd_ptr];
                end
            end
        end
    end

endmodule

// File: rtl/cnn_frame_scheduler.sv
// Frame sequencer between the control register block and the CNN core:
// start pulses, hardware pixel streaming from a FIFO, completion pulse and a
// result watchdog. Abort from any busy state returns to IDLE, resets the CNN
// and flushes the FIFO. All outputs come straight from flops.
module cnn_frame_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int PIX_W          = 8,
    parameter int FRAME_PIXELS   = 1024,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_cmd_start,
    input  logic                          i_cmd_abort,
    input  logic                          i_in_pixel_valid,
    input  logic [PIX_W-1:0]              i_in_pixel_data,
    output logic                          o_in_pixel_ready,
    input  logic                          i_cnn_busy,
    input  logic                          i_cnn_result_valid,
    output logic                          o_cnn_start,
    output logic                          o_cnn_reset,
    output logic                          o_frame_start,
    output logic                          o_pixel_valid,
    output logic [PIX_W-1:0]              o_pixel_data,
    output logic                          o_frame_complete,
    output logic                          o_sched_busy,
    output logic                          o_frame_done,
    output logic [31:0]                   o_frame_count,
    output logic [31:0]                   o_error_code,
    output logic [2:0]                    o_dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   o_dbg_fifo_count
);

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_START    = ST_START;
    localparam logic [2:0] S_STREAM   = ST_STREAM;
    localparam logic [2:0] S_COMPLETE = ST_COMPLETE;
    localparam logic [2:0] S_WAIT     = ST_WAIT_RESULT;

    localparam int IDX_W = $clog2(FRAME_PIXELS);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);
    localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [TMR_W-1:0] r_timer;
    logic             r_cnn_start;
    logic             r_cnn_reset;
    logic             r_frame_start;
    logic             r_pixel_valid;
    logic             r_frame_complete;
    logic             r_sched_busy;
    logic             r_frame_done;
    logic [31:0]      r_frame_count;
    logic [31:0]      r_error_code;

    logic             w_abort;
    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic             w_result;
    logic             w_timeout;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    // Abort only acts when a frame is in flight, and outranks everything else.
    assign w_abort   = i_cmd_abort && (r_state != S_IDLE);
    assign w_pop     = (r_state == S_STREAM) && !w_fifo_empty && !i_cmd_abort;
    assign w_result  = (r_state == S_WAIT) && i_cnn_result_valid && !i_cmd_abort;
    assign w_timeout = (r_state == S_WAIT) && !i_cnn_result_valid && !i_cmd_abort
                       && (r_timer == LAST_TMR);
    assign w_flush   = w_abort || w_timeout;
    assign w_push    = i_in_pixel_valid && !w_fifo_full;

    assign o_in_pixel_ready = !w_fifo_full;
    assign o_cnn_start      = r_cnn_start;
    assign o_cnn_reset      = r_cnn_reset;
    assign o_frame_start    = r_frame_start;
    assign o_pixel_valid    = r_pixel_valid;
    assign o_frame_complete = r_frame_complete;
    assign o_sched_busy     = r_sched_busy;
    assign o_frame_done     = r_frame_done;
    assign o_frame_count    = r_frame_count;
    assign o_error_code     = r_error_code;
    assign o_dbg_state      = r_state;

    cnn_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (i_in_pixel_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (o_pixel_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (o_dbg_fifo_count)
    );

    // Next-state selection for the frame FSM.
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_start && !i_cmd_abort && !i_cnn_busy) begin
                        w_next_state = S_START;
                    end
                end
                S_START:    w_next_state = S_STREAM;
                S_STREAM: begin
                    if (w_pop && (r_idx == LAST_IDX)) begin
                        w_next_state = S_COMPLETE;
                    end
                end
                S_COMPLETE: w_next_state = S_WAIT;
                S_WAIT: begin
                    if (w_result || w_timeout) begin
                        w_next_state = S_IDLE;
                    end
                end
                default:    w_next_state = S_IDLE;
            endcase
        end
    end

    // State, counters, status registers and one-cycle output pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_timer          <= '0;
            r_cnn_start      <= 1'b0;
            r_cnn_reset      <= 1'b0;
            r_frame_start    <= 1'b0;
            r_pixel_valid    <= 1'b0;
            r_frame_complete <= 1'b0;
            r_sched_busy     <= 1'b0;
            r_frame_done     <= 1'b0;
            r_frame_count    <= '0;
            r_error_code     <= ERR_NONE;
        end else begin
            r_state          <= w_next_state;
            r_sched_busy     <= (w_next_state != S_IDLE);
            r_cnn_start      <= (r_state == S_START) && !w_abort;
            r_frame_start    <= (r_state == S_START) && !w_abort;
            r_pixel_valid    <= w_pop;
            r_frame_complete <= (r_state == S_COMPLETE) && !w_abort;
            r_cnn_reset      <= w_abort || w_timeout;
            r_frame_done     <= w_result;

            if (r_state == S_START) begin
                r_idx <= '0;
            end else if (w_pop) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (r_state == S_COMPLETE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_result) begin
                r_frame_count <= r_frame_count + 32'd1;
            end

            if (w_abort) begin
                r_error_code <= ERR_ABORTED;
            end else if (w_timeout) begin
                r_error_code <= ERR_CNN_TIMEOUT;
            end else if ((r_state == S_IDLE) && i_cmd_start && !i_cmd_abort) begin
                r_error_code <= i_cnn_busy ? ERR_INVALID_START : ERR_NONE;
            end
        end
    end

endmodule
